// File: rtl/enigma_pkg.sv
// Shared types for the Enigma controller slice: letter type, alphabet size, FSM states.
package enigma_pkg;

  typedef logic [4:0] letter_t;

  localparam int unsigned ALPHA_LEN = 26;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STEP,
    ST_SETTLE,
    ST_OUT
  } enigma_ctrl_state_e;

  function automatic logic is_letter(input letter_t c);
    return c < letter_t'(ALPHA_LEN);
  endfunction

endpackage

// File: rtl/enigma_step_decode.sv
// Rotor step-enable decode: right always steps, middle on either notch (double step),
// left on the middle notch. Notches are the pre-step rotor positions.
module enigma_step_decode (
  input  logic en,
  input  logic notch_r,
  input  logic notch_m,
  output logic step_r,
  output logic step_m,
  output logic step_l
);

  assign step_r = en;
  assign step_m = en & (notch_r | notch_m);
  assign step_l = en & notch_m;

endmodule

// File: rtl/enigma_ctrl.sv
// Enigma letter sequencer: key handshake, rotor step strobes, settle wait, cipher output.
// Optional delivered-letter counter enabled by defining ENIGMA_CTRL_STATS_EN.
module enigma_ctrl
  import enigma_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
`ifdef ENIGMA_CTRL_STATS_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             key_valid,
  input  logic [4:0]       key_char,
  output logic             key_ready,
  input  logic             cfg_load,
  output logic             load_key,
  input  logic             notch_r,
  input  logic             notch_m,
  output logic             new_char,
  output logic             step_r,
  output logic             step_m,
  output logic             step_l,
  output logic [4:0]       dp_char,
  input  logic [4:0]       enc_char_in,
  output logic             out_valid,
  output logic [4:0]       out_char,
  input  logic             out_ready,
  output logic             key_err
`ifdef ENIGMA_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] char_count
`endif
);

  localparam int unsigned  CW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYC - 1);

  enigma_ctrl_state_e state_q, state_d;
  letter_t            dp_char_q, dp_char_d;
  letter_t            out_char_q, out_char_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               load_pend_q, load_pend_d;
  logic               key_err_q, key_err_d;
  logic               step_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      dp_char_q   <= '0;
      out_char_q  <= '0;
      cnt_q       <= '0;
      load_pend_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dp_char_q   <= dp_char_d;
      out_char_q  <= out_char_d;
      cnt_q       <= cnt_d;
      load_pend_q <= load_pend_d;
      key_err_q   <= key_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dp_char_d   = dp_char_q;
    out_char_d  = out_char_q;
    cnt_d       = cnt_q;
    // a load request seen in any busy state is remembered until LOAD services it
    load_pend_d = load_pend_q | cfg_load;
    key_err_d   = 1'b0;
    key_ready   = 1'b0;
    load_key    = 1'b0;
    new_char    = 1'b0;
    out_valid   = 1'b0;
    step_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        key_ready = ~cfg_load & ~load_pend_q & reset_n;
        if (cfg_load || load_pend_q) begin
          state_d = ST_LOAD;
        end else if (key_valid) begin
          if (is_letter(key_char)) begin
            dp_char_d = key_char;
            state_d   = ST_STEP;
          end else begin
            key_err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        load_key    = 1'b1;
        load_pend_d = 1'b0;
        state_d     = ST_IDLE;
      end
      ST_STEP: begin
        new_char = 1'b1;
        step_en  = 1'b1;
        cnt_d    = CNT_INIT;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          out_char_d = enc_char_in;
          state_d    = ST_OUT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  enigma_step_decode u_step_decode (
    .en      (step_en),
    .notch_r (notch_r),
    .notch_m (notch_m),
    .step_r  (step_r),
    .step_m  (step_m),
    .step_l  (step_l)
  );

  assign dp_char  = dp_char_q;
  assign out_char = out_char_q;
  assign key_err  = key_err_q;

`ifdef ENIGMA_CTRL_STATS_EN
  logic [CNT_W-1:0] char_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      char_count_q <= '0;
    end else if (load_key) begin
      char_count_q <= '0;
    end else if (out_valid && out_ready) begin
      char_count_q <= char_count_q + 1'b1;
    end
  end

  assign char_count = char_count_q;
`endif

endmodule

// File: tb/tb_enigma_ctrl.sv
// Self-checking bench for enigma_ctrl: directed table, multi-cycle corner sequences,
// and random letters against an odometer-style rotor model.
module tb_enigma_ctrl;

  localparam int unsigned SC      = 2;
  localparam int          NOTCH_R = 16;
  localparam int          NOTCH_M = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        key_valid;
  logic [4:0]  key_char;
  logic        key_ready;
  logic        cfg_load;
  logic        load_key;
  logic        notch_r;
  logic        notch_m;
  logic        new_char;
  logic        step_r;
  logic        step_m;
  logic        step_l;
  logic [4:0]  dp_char;
  logic [4:0]  enc_char_in;
  logic        out_valid;
  logic [4:0]  out_char;
  logic        out_ready;
  logic        key_err;
`ifdef ENIGMA_CTRL_STATS_EN
  logic [15:0] char_count;
`endif

  always #5 clk = ~clk;

  enigma_ctrl #(
    .SETTLE_CYC (SC)
`ifdef ENIGMA_CTRL_STATS_EN
    , .CNT_W    (16)
`endif
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_valid   (key_valid),
    .key_char    (key_char),
    .key_ready   (key_ready),
    .cfg_load    (cfg_load),
    .load_key    (load_key),
    .notch_r     (notch_r),
    .notch_m     (notch_m),
    .new_char    (new_char),
    .step_r      (step_r),
    .step_m      (step_m),
    .step_l      (step_l),
    .dp_char     (dp_char),
    .enc_char_in (enc_char_in),
    .out_valid   (out_valid),
    .out_char    (out_char),
    .out_ready   (out_ready),
    .key_err     (key_err)
`ifdef ENIGMA_CTRL_STATS_EN
    , .char_count (char_count)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int pr, pm, pl;
  int exp_count = 0;

  typedef struct {
    logic [4:0] key;
    logic       nr;
    logic       nm;
    logic [4:0] enc;
    logic       esm;
    logic       esl;
    int         stall;
  } vec_t;

  vec_t tbl[7];

  function automatic vec_t mk(input logic [4:0] k, input logic nr, input logic nm,
                              input logic [4:0] e, input logic sm, input logic sl,
                              input int st);
    vec_t v;
    v.key = k; v.nr = nr; v.nm = nm; v.enc = e; v.esm = sm; v.esl = sl; v.stall = st;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk5(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_count(input string name);
`ifdef ENIGMA_CTRL_STATS_EN
    n_chk++;
    if (char_count !== 16'(exp_count)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, char_count, exp_count, $time);
    end
`else
    if (name.len() == 0) $display("empty count tag");
`endif
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic reload_model();
    pr = NOTCH_R - 3;
    pm = NOTCH_M - 1;
    pl = 0;
  endtask

  task automatic do_letter(input logic [4:0] key, input logic nr, input logic nm,
                           input logic [4:0] enc, input logic esm, input logic esl,
                           input int stall, input logic load_in_out);
    chk1("idle_ready", key_ready, 1'b1);
    key_valid   = 1'b1;
    key_char    = key;
    notch_r     = nr;
    notch_m     = nm;
    enc_char_in = ~enc;
    #1;
    chk1("accept_ready", key_ready, 1'b1);
    nxt();
    key_valid = 1'b0;
    key_char  = 5'($urandom);
    #1;
    if (key >= 26) begin
      chk1("err_pulse", key_err, 1'b1);
      chk1("err_no_step", new_char, 1'b0);
      chk1("err_idle_ready", key_ready, 1'b1);
      nxt();
      chk1("err_clear", key_err, 1'b0);
      chk1("err_no_step2", new_char, 1'b0);
      chk_count("err_count");
      return;
    end
    chk1("new_char", new_char, 1'b1);
    chk1("step_r", step_r, 1'b1);
    chk1("step_m", step_m, esm);
    chk1("step_l", step_l, esl);
    chk5("dp_char", dp_char, key);
    chk1("step_busy", key_ready, 1'b0);
    chk1("no_err", key_err, 1'b0);
    // notches after the step must not influence anything
    notch_r = 1'($urandom);
    notch_m = 1'($urandom);
    for (int i = 0; i < int'(SC); i++) begin
      nxt();
      if (i == int'(SC) - 1) enc_char_in = enc;
      #1;
      chk1("settle_quiet", new_char | step_r | step_m | step_l, 1'b0);
      chk1("settle_not_valid", out_valid, 1'b0);
    end
    nxt();
    enc_char_in = ~enc;
    #1;
    chk1("out_valid", out_valid, 1'b1);
    chk5("out_char", out_char, enc);
    chk5("dp_held", dp_char, key);
    for (int i = 0; i < stall; i++) begin
      cfg_load = load_in_out && (i == 1);
      nxt();
      cfg_load = 1'b0;
      #1;
      chk1("stall_valid", out_valid, 1'b1);
      chk5("stall_char", out_char, enc);
      chk1("stall_no_load", load_key, 1'b0);
    end
    out_ready = 1'b1;
    nxt();
    out_ready = 1'b0;
    exp_count++;
    #1;
    chk1("done_not_valid", out_valid, 1'b0);
    if (load_in_out) begin
      chk1("pend_blocks_key", key_ready, 1'b0);
      chk1("pend_no_load_yet", load_key, 1'b0);
      nxt();
      chk1("pend_load", load_key, 1'b1);
      exp_count = 0;
      reload_model();
      nxt();
      chk1("pend_load_done", load_key, 1'b0);
    end
    chk1("back_ready", key_ready, 1'b1);
    chk_count("count");
  endtask

  // Rotor odometer: a middle rotor sitting on its notch carries itself and the left one.
  task automatic model_letter(input logic [4:0] key, input logic [4:0] enc, input int stall);
    logic nr, nm, esm, esl;
    int opm, opl;
    if (key < 26) begin
      nr  = (pr == NOTCH_R);
      nm  = (pm == NOTCH_M);
      opm = pm;
      opl = pl;
      if (pm == NOTCH_M) begin
        pm = (pm + 1) % 26;
        pl = (pl + 1) % 26;
      end else if (pr == NOTCH_R) begin
        pm = (pm + 1) % 26;
      end
      pr  = (pr + 1) % 26;
      esm = (pm != opm);
      esl = (pl != opl);
    end else begin
      nr  = 1'($urandom);
      nm  = 1'($urandom);
      esm = 1'b0;
      esl = 1'b0;
    end
    do_letter(key, nr, nm, enc, esm, esl, stall, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] k;
    tbl[0] = mk(7,  0, 0, 19, 0, 0, 0);
    tbl[1] = mk(3,  1, 0, 5,  1, 0, 1);
    tbl[2] = mk(11, 0, 1, 0,  1, 1, 0);
    tbl[3] = mk(25, 1, 1, 25, 1, 1, 2);
    tbl[4] = mk(28, 0, 0, 0,  0, 0, 0);
    tbl[5] = mk(0,  0, 0, 1,  0, 0, 0);
    tbl[6] = mk(31, 1, 1, 9,  0, 0, 0);

    reset_n = 1'b0; key_valid = 1'b0; key_char = '0; cfg_load = 1'b0;
    notch_r = 1'b0; notch_m = 1'b0; enc_char_in = '0; out_ready = 1'b0;
    reload_model();
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_key_ready", key_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_new_char", new_char, 1'b0);
    chk5("rst_out_char", out_char, 5'd0);
    chk5("rst_dp_char", dp_char, 5'd0);
    reset_n = 1'b1;
    nxt();
    chk1("post_rst_ready", key_ready, 1'b1);
    chk_count("rst_count");

    for (int i = 0; i < 7; i++)
      do_letter(tbl[i].key, tbl[i].nr, tbl[i].nm, tbl[i].enc,
                tbl[i].esm, tbl[i].esl, tbl[i].stall, 1'b0);

    // load and key in the same cycle: load first, key accepted afterwards
    cfg_load = 1'b1; key_valid = 1'b1; key_char = 5'd12;
    #1;
    chk1("load_blocks_key", key_ready, 1'b0);
    nxt();
    cfg_load = 1'b0;
    #1;
    chk1("load_strobe", load_key, 1'b1);
    chk1("load_no_key", key_ready, 1'b0);
    chk1("load_no_step", new_char, 1'b0);
    exp_count = 0;
    nxt();
    chk1("load_one_cycle", load_key, 1'b0);
    chk_count("load_count_clear");
    do_letter(5'd12, 1'b0, 1'b0, 5'd17, 1'b0, 1'b0, 0, 1'b0);

    // consumer stalls while a load is requested during OUT
    do_letter(5'd4, 1'b1, 1'b0, 5'd22, 1'b1, 1'b0, 5, 1'b1);

    reload_model();
    for (int n = 0; n < 150; n++) begin
      k = ($urandom_range(0, 7) == 0) ? 5'(26 + $urandom_range(0, 5))
                                       : 5'($urandom_range(0, 25));
      model_letter(k, 5'($urandom_range(0, 25)), int'($urandom_range(0, 3)));
    end

    // reset while the letter is settling
    key_valid = 1'b1; key_char = 5'd9; notch_r = 1'b1; notch_m = 1'b1;
    nxt();
    key_valid = 1'b0;
    nxt();
    #2;
    reset_n = 1'b0;
    #1;
    chk1("mid_rst_ready", key_ready, 1'b0);
    chk1("mid_rst_valid", out_valid, 1'b0);
    chk1("mid_rst_step", new_char | step_r | step_m | step_l, 1'b0);
    chk1("mid_rst_load", load_key, 1'b0);
    chk1("mid_rst_err", key_err, 1'b0);
    chk5("mid_rst_dp", dp_char, 5'd0);
    chk5("mid_rst_out", out_char, 5'd0);
    nxt();
    reset_n = 1'b1;
    exp_count = 0;
    nxt();
    chk1("mid_rst_release_ready", key_ready, 1'b1);
    chk1("mid_rst_release_valid", out_valid, 1'b0);
    chk_count("mid_rst_count");
    do_letter(5'd2, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
